// File: rtl/alu_func_sel_pipe.sv
// ALU function-select stage with a 2-entry output FIFO and a stall counter.
// The selected ALU control code and its ALUOp are captured on accept and
// presented from registers only, so out_* carry no combinational path from inputs.
//
// state   | meaning
// --------+-----------------------------------------------
// S_EMPTY | no buffered entry, out_valid=0, in_ready=1
// S_ONE   | head valid, tail free, out_valid=1, in_ready=1
// S_FULL  | head and tail valid, out_valid=1, in_ready=0
module alu_func_sel_pipe #(
    parameter int             W        = 6,
    parameter logic [W-1:0]   ADD_CODE = 6'b100000,
    parameter logic [W-1:0]   SUB_CODE = 6'b100010,
    parameter int             CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALUOp,
    input  logic [W-1:0]     Opcode,
    input  logic [W-1:0]     Funct,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_code,
    output logic [1:0]       out_src,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    localparam int EW = W + 2;

    state_t           state_q, state_d;
    logic [EW-1:0]    head_q, head_d;
    logic [EW-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [W-1:0]     sel_code;
    logic [EW-1:0]    sel_entry;
    logic             push, pop;

    assign in_ready  = (state_q != S_FULL);
    assign out_valid = (state_q != S_EMPTY);
    assign out_code  = head_q[W-1:0];
    assign out_src   = head_q[EW-1:W];
    assign stall_cnt = stall_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Code selection from ALUOp; each entry keeps its ALUOp alongside the code.
    always_comb begin
        sel_code = ADD_CODE;
        case (ALUOp)
            2'b00:   sel_code = ADD_CODE;
            2'b01:   sel_code = SUB_CODE;
            2'b10:   sel_code = Funct;
            default: sel_code = Opcode;
        endcase
        sel_entry = {ALUOp, sel_code};
    end

    // Occupancy next-state and FIFO slot updates; head is always slot 0.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (push) begin
                        head_d  = sel_entry;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (push && pop) begin
                        head_d = sel_entry;
                    end else if (push) begin
                        tail_d  = sel_entry;
                        state_d = S_FULL;
                    end else if (pop) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (pop) begin
                        head_d  = tail_q;
                        state_d = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // Saturating count of cycles where the head is offered but not taken.
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && !flush && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // State, FIFO slots and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_alu_func_sel_pipe.sv
// Directed bench for alu_func_sel_pipe: a scoreboard queue is filled as entries
// are issued and drained by a monitor whenever the DUT hands off its head entry.
module tb_alu_func_sel_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid, in_ready;
    logic [1:0] ALUOp;
    logic [5:0] Opcode, Funct;
    logic       flush;
    logic       out_valid, out_ready;
    logic [5:0] out_code;
    logic [1:0] out_src;
    logic [15:0] stall_cnt;

    logic       in_valid1, in_ready1;
    logic       out_valid1;
    logic [5:0] out_code1;
    logic [1:0] out_src1;
    logic [2:0] stall_cnt1;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] sb[$];

    alu_func_sel_pipe u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUOp     (ALUOp),
        .Opcode    (Opcode),
        .Funct     (Funct),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_src   (out_src),
        .stall_cnt (stall_cnt)
    );

    alu_func_sel_pipe #(.CNT_W(3)) u_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .ALUOp     (2'b00),
        .Opcode    (6'h00),
        .Funct     (6'h00),
        .flush     (1'b0),
        .out_valid (out_valid1),
        .out_ready (1'b0),
        .out_code  (out_code1),
        .out_src   (out_src1),
        .stall_cnt (stall_cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [5:0] opc, input logic [5:0] fn,
                         input logic accept, input logic [5:0] exp_code);
        ALUOp    = op;
        Opcode   = opc;
        Funct    = fn;
        in_valid = 1'b1;
        if (accept) sb.push_back({op, exp_code});
    endtask

    // Monitor: whenever the head is handed off, compare it to the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("pop_unexpected", 32'(out_code), 32'hFFFF_FFFF);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                check("pop_code", 32'(out_code), 32'(e[5:0]));
                check("pop_src", 32'(out_src), 32'(e[7:6]));
            end
        end
    end

    initial begin
        logic [5:0] mode_exp [4];
        mode_exp[0] = 6'h20;
        mode_exp[1] = 6'h22;
        mode_exp[2] = 6'h2A;
        mode_exp[3] = 6'h23;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ALUOp = 2'b00; Opcode = 6'h00; Funct = 6'h00; in_valid1 = 1'b0;
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_code", 32'(out_code), 32'd0);
        check("rst_out_src", 32'(out_src), 32'd0);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        rst = 1'b0;
        step();

        // All four modes back to back with the sink always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(2'(i), 6'h23, 6'h2A, 1'b1, mode_exp[i]);
            step();
            check("mode_valid", 32'(out_valid), 32'd1);
            check("mode_code", 32'(out_code), 32'(mode_exp[i]));
        end
        in_valid = 1'b0;
        step();
        check("mode_drained", 32'(out_valid), 32'd0);
        check("mode_stall", 32'(stall_cnt), 32'd0);

        // Fill with the sink blocked: third entry must be refused.
        out_ready = 1'b0;
        issue(2'b10, 6'h23, 6'h24, 1'b1, 6'h24);
        step();
        check("fill_a_ready", 32'(in_ready), 32'd1);
        check("fill_a_code", 32'(out_code), 32'h24);
        check("fill_a_stall", 32'(stall_cnt), 32'd0);
        issue(2'b11, 6'h0D, 6'h24, 1'b1, 6'h0D);
        step();
        check("fill_b_ready", 32'(in_ready), 32'd0);
        check("fill_b_code", 32'(out_code), 32'h24);
        check("fill_b_stall", 32'(stall_cnt), 32'd1);
        issue(2'b00, 6'h0D, 6'h24, 1'b0, 6'h20);
        step();
        check("fill_c_ready", 32'(in_ready), 32'd0);
        check("fill_c_code", 32'(out_code), 32'h24);
        check("fill_c_stall", 32'(stall_cnt), 32'd2);
        in_valid = 1'b0;
        step();
        check("fill_hold_src", 32'(out_src), 32'd2);
        check("fill_hold_stall", 32'(stall_cnt), 32'd3);

        // Drain from FULL.
        out_ready = 1'b1;
        step();
        check("drain1_valid", 32'(out_valid), 32'd1);
        check("drain1_code", 32'(out_code), 32'h0D);
        check("drain1_stall", 32'(stall_cnt), 32'd3);
        step();
        check("drain2_valid", 32'(out_valid), 32'd0);
        check("drain2_ready", 32'(in_ready), 32'd1);

        // Simultaneous push and pop while holding one entry.
        issue(2'b00, 6'h00, 6'h00, 1'b1, 6'h20);
        step();
        issue(2'b01, 6'h00, 6'h00, 1'b1, 6'h22);
        step();
        check("pp_valid", 32'(out_valid), 32'd1);
        check("pp_code", 32'(out_code), 32'h22);
        check("pp_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        step();
        check("pp_drained", 32'(out_valid), 32'd0);

        // Flush while FULL with a pending input.
        out_ready = 1'b0;
        issue(2'b10, 6'h00, 6'h11, 1'b1, 6'h11);
        step();
        issue(2'b11, 6'h05, 6'h11, 1'b1, 6'h05);
        step();
        check("pre_flush_ready", 32'(in_ready), 32'd0);
        check("pre_flush_stall", 32'(stall_cnt), 32'd4);
        flush = 1'b1;
        issue(2'b00, 6'h00, 6'h00, 1'b0, 6'h20);
        step();
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_ready", 32'(in_ready), 32'd1);
        check("flush_stall", 32'(stall_cnt), 32'd4);
        sb.delete();
        flush = 1'b0;
        in_valid = 1'b0;
        step();
        check("post_flush_valid", 32'(out_valid), 32'd0);
        check("post_flush_stall", 32'(stall_cnt), 32'd4);

        // Reset while FULL with stall_cnt at 5.
        issue(2'b00, 6'h00, 6'h00, 1'b1, 6'h20);
        step();
        issue(2'b01, 6'h00, 6'h00, 1'b1, 6'h22);
        step();
        check("pre_rst_stall", 32'(stall_cnt), 32'd5);
        check("pre_rst_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_code", 32'(out_code), 32'd0);
        check("mid_rst_stall", 32'(stall_cnt), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        sb.delete();
        rst = 1'b0;
        step();

        // Saturation on the 3-bit counter instance.
        in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        check("sat_valid", 32'(out_valid1), 32'd1);
        check("sat_code", 32'(out_code1), 32'h20);
        check("sat_src", 32'(out_src1), 32'd0);
        check("sat_ready", 32'(in_ready1), 32'd1);
        for (int i = 0; i < 6; i++) step();
        check("sat_stall6", 32'(stall_cnt1), 32'd6);
        for (int i = 0; i < 4; i++) step();
        check("sat_stall10", 32'(stall_cnt1), 32'd7);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
